// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: FSM states, clock-mode constants, default word width, SCLK ratio.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package spi_slave_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // SCLK idle level.
    localparam bit CPOL_IDLE_LOW     = 1'b0;
    localparam bit CPOL_IDLE_HIGH    = 1'b1;

    // Which SCLK edge samples MOSI.
    localparam bit CPHA_SAMPLE_LEAD  = 1'b0;
    localparam bit CPHA_SAMPLE_TRAIL = 1'b1;

    localparam int SPI_DATA_W        = 8;

    // The SPI master never runs SCLK faster than clk / SCLK_MIN_DIV.
    localparam int SCLK_MIN_DIV      = 8;

    // A leading edge leaves the idle level: rising for CPOL=0, falling for CPOL=1.
    function automatic logic leading_edge(input logic cpol, input logic rise, input logic fall);
        return cpol ? fall : rise;
    endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus one-cycle rise/fall pulses.
// Latency: 2 clk to dout; edge pulses coincide with the new dout value.
// Backpressure: none, free-running.
module spi_slave_sync_edge #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Metastability stage, synced value and its one-cycle-old copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder oversampling SCLK/CS_N/MOSI in the clk domain; one word in and one out per frame.
// Latency: pin edge to internal action 3 clk; CS fall to MISO valid 3 clk.
// Backpressure: none on RX (rx_valid pulse); TX is a one-word buffer, tx_ready while empty.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int                DATA_W  = SPI_DATA_W,
    parameter bit                CPOL    = CPOL_IDLE_LOW,
    parameter bit                CPHA    = CPHA_SAMPLE_LEAD,
    parameter logic [DATA_W-1:0] TX_FILL = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_state_t        state;
    spi_state_t        state_nx;

    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_rise;
    logic              cs_fall;
    logic              mosi_s;
    logic              sclk_lvl_unused;
    logic              cs_lvl_unused;
    logic              mosi_rise_unused;
    logic              mosi_fall_unused;

    logic              lead_edge;
    logic              trail_edge;
    logic              sample_edge;
    logic              shift_edge;
    logic              start;
    logic              in_frame;
    logic              tx_load;
    logic              tx_capture;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_buf;
    logic              tx_full;

    // SCLK resets to its idle level so no false edge appears on reset release.
    spi_slave_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_sclk),
        .dout (sclk_lvl_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // CS_N resets to 0: a CS held low through reset has to rise and fall again to start a frame.
    spi_slave_sync_edge #(.RST_VAL(1'b0)) u_sync_cs (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_cs_n),
        .dout (cs_lvl_unused),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_slave_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_mosi),
        .dout (mosi_s),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    assign lead_edge   = leading_edge(CPOL, sclk_rise, sclk_fall);
    assign trail_edge  = leading_edge(~CPOL, sclk_rise, sclk_fall);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign start       = (state == ST_IDLE) && cs_fall;
    // SCLK edges arriving in the same cycle as the CS rise belong to no word.
    assign in_frame    = (state == ST_ACTIVE) && !cs_rise;

    // A shift edge with bit_cnt==0 begins a new word; CPHA=0 also preloads at frame start
    // so the MSB is on MISO before the first sampling edge.
    assign tx_load     = (in_frame && shift_edge && (bit_cnt == '0)) || (!CPHA && start);
    assign tx_capture  = tx_valid && !tx_full;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Frame starts only on a CS fall and ends on a CS rise.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (cs_fall) state_nx = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Receive path: shift MOSI in on sample edges, publish each completed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if ((state == ST_ACTIVE) && cs_rise) begin
                bit_cnt <= '0;
            end else if (in_frame && sample_edge) begin
                rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                if (bit_cnt == LAST_BIT) begin
                    rx_data  <= {rx_shift[DATA_W-2:0], mosi_s};
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // Transmit path: load/shift tx_shift, and the one-word buffer fed by the ready/valid port.
    // A capture in the same cycle as a load is seen by the load as an empty buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift    <= TX_FILL;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (tx_load) begin
                if (tx_full) begin
                    tx_shift <= tx_buf;
                end else begin
                    tx_shift    <= TX_FILL;
                    tx_underrun <= 1'b1;
                end
            end else if (start) begin
                tx_shift <= TX_FILL;
            end else if (in_frame && shift_edge) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (tx_capture) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end else if (tx_load) begin
                tx_full <= 1'b0;
            end
        end
    end

    assign busy        = (state == ST_ACTIVE);
    assign spi_miso_oe = busy;
    assign spi_miso    = busy & tx_shift[DATA_W-1];
    assign tx_ready    = !tx_full;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 and a mode-3 instance driven by a bit-banged SPI master.
// Latency: SCLK runs at clk/8; MISO is sampled by the master on its sampling edge.
// Backpressure: TX words are pushed through the ready/valid port; RX has none.
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam int HALF = SCLK_MIN_DIV / 2;

    logic       clk = 1'b0;
    logic       rst;

    logic       sclk0, cs_n0, mosi0, miso0, miso_oe0, tx_valid0, tx_ready0, rx_valid0, tx_underrun0, busy0;
    logic [7:0] tx_data0, rx_data0;
    logic       sclk3, cs_n3, mosi3, miso3, miso_oe3, tx_valid3, tx_ready3, rx_valid3, tx_underrun3, busy3;
    logic [7:0] tx_data3, rx_data3;

    int n_chk  = 0;
    int n_fail = 0;
    int und0 = 0, und3 = 0, rxc0 = 0, rxc3 = 0;
    int und_mid = 0;
    int base_und, base_rx;

    logic [7:0] rx_q0[$], rx_q3[$], tx_q0[$], tx_q3[$];

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(8), .CPOL(CPOL_IDLE_LOW), .CPHA(CPHA_SAMPLE_LEAD), .TX_FILL(8'hFF)) u_dut0 (
        .clk(clk), .rst(rst), .spi_sclk(sclk0), .spi_cs_n(cs_n0), .spi_mosi(mosi0),
        .spi_miso(miso0), .spi_miso_oe(miso_oe0), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .tx_underrun(tx_underrun0), .busy(busy0)
    );

    spi_slave #(.DATA_W(8), .CPOL(CPOL_IDLE_HIGH), .CPHA(CPHA_SAMPLE_TRAIL), .TX_FILL(8'hFF)) u_dut3 (
        .clk(clk), .rst(rst), .spi_sclk(sclk3), .spi_cs_n(cs_n3), .spi_mosi(mosi3),
        .spi_miso(miso3), .spi_miso_oe(miso_oe3), .tx_data(tx_data3), .tx_valid(tx_valid3),
        .tx_ready(tx_ready3), .rx_data(rx_data3), .rx_valid(rx_valid3),
        .tx_underrun(tx_underrun3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Monitors sample 1 time unit after the falling edge; pop RX expectations on each pulse.
    always @(negedge clk) begin
        #1;
        if (tx_underrun0) und0++;
        if (tx_underrun3) und3++;
        if (rx_valid0) begin
            rxc0++;
            if (rx_q0.size() > 0) chk("rx0_data", rx_data0, rx_q0.pop_front());
            else                  chk("rx0_unexpected", rx_valid0, 0);
        end
        if (rx_valid3) begin
            rxc3++;
            if (rx_q3.size() > 0) chk("rx3_data", rx_data3, rx_q3.pop_front());
            else                  chk("rx3_unexpected", rx_valid3, 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cs(input int d, input logic v);
        if (d == 0) cs_n0 = v; else cs_n3 = v;
    endtask

    task automatic chk_reset(input int d);
        if (d == 0) begin
            chk("rst0_miso", miso0, 0);      chk("rst0_oe", miso_oe0, 0);
            chk("rst0_ready", tx_ready0, 1); chk("rst0_rxd", rx_data0, 0);
            chk("rst0_rxv", rx_valid0, 0);   chk("rst0_und", tx_underrun0, 0);
            chk("rst0_busy", busy0, 0);
        end else begin
            chk("rst3_miso", miso3, 0);      chk("rst3_oe", miso_oe3, 0);
            chk("rst3_ready", tx_ready3, 1); chk("rst3_rxd", rx_data3, 0);
            chk("rst3_rxv", rx_valid3, 0);   chk("rst3_und", tx_underrun3, 0);
            chk("rst3_busy", busy3, 0);
        end
    endtask

    // Push one TX word through ready/valid, waiting a bounded time for tx_ready.
    task automatic push_tx(input int d, input logic [7:0] w);
        int k = 0;
        while (((d == 0) ? tx_ready0 : tx_ready3) !== 1'b1 && k < 400) begin
            wait_clks(1);
            k++;
        end
        chk("tx_ready_wait", (d == 0) ? tx_ready0 : tx_ready3, 1);
        if (d == 0) begin tx_data0 = w; tx_valid0 = 1'b1; end
        else        begin tx_data3 = w; tx_valid3 = 1'b1; end
        wait_clks(1);
        tx_valid0 = 1'b0;
        tx_valid3 = 1'b0;
        chk("tx_ready_drop", (d == 0) ? tx_ready0 : tx_ready3, 0);
    endtask

    // Clock nbits of w out MSB first; optionally compare the MISO word with the TX queue.
    task automatic xfer_word(input int d, input logic [7:0] w, input int nbits, input bit cmp);
        logic [7:0] cap;
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            if (d == 0) begin
                mosi0 = w[7-i];
                wait_clks(HALF);
                cap   = {cap[6:0], miso0};
                sclk0 = 1'b1;
                wait_clks(HALF);
                if (i == nbits - 1) und_mid = und0;
                sclk0 = 1'b0;
            end else begin
                sclk3 = 1'b0;
                mosi3 = w[7-i];
                wait_clks(HALF);
                cap   = {cap[6:0], miso3};
                sclk3 = 1'b1;
                wait_clks(HALF);
            end
        end
        if (cmp) begin
            if (d == 0) begin
                if (tx_q0.size() > 0) chk("miso0_word", cap, tx_q0.pop_front());
                else                  chk("miso0_noexp", tx_q0.size(), 1);
            end else begin
                if (tx_q3.size() > 0) chk("miso3_word", cap, tx_q3.pop_front());
                else                  chk("miso3_noexp", tx_q3.size(), 1);
            end
        end
    endtask

    task automatic begin_frame(input int d);
        set_cs(d, 1'b0);
        wait_clks(HALF);
        chk("busy_start", (d == 0) ? busy0 : busy3, 1);
        chk("oe_start", (d == 0) ? miso_oe0 : miso_oe3, 1);
    endtask

    // Raise CS and check the frame is closed within 3 clk.
    task automatic end_frame(input int d);
        wait_clks(HALF);
        set_cs(d, 1'b1);
        wait_clks(3);
        chk("busy_end", (d == 0) ? busy0 : busy3, 0);
        chk("oe_end", (d == 0) ? miso_oe0 : miso_oe3, 0);
        wait_clks(HALF);
    endtask

    task automatic frame(input int d, input logic [7:0] w);
        begin_frame(d);
        if (d == 0) rx_q0.push_back(w); else rx_q3.push_back(w);
        xfer_word(d, w, 8, 1'b1);
        end_frame(d);
    endtask

    initial begin
        rst = 1'b1;
        sclk0 = 1'b0; cs_n0 = 1'b1; mosi0 = 1'b0; tx_valid0 = 1'b0; tx_data0 = '0;
        sclk3 = 1'b1; cs_n3 = 1'b1; mosi3 = 1'b0; tx_valid3 = 1'b0; tx_data3 = '0;
        wait_clks(4);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        wait_clks(6);

        // Mode 0: 0xA5 preloaded, master sends 0x3C. The trailing edge after bit 8 preloads
        // the next word from an empty buffer, so the only underrun comes after the last sample.
        push_tx(0, 8'hA5);
        tx_q0.push_back(8'hA5);
        base_und = und0; base_rx = rxc0;
        frame(0, 8'h3C);
        chk("t1_und_during_word", und_mid - base_und, 0);
        chk("t1_und_after_word", und0 - base_und, 1);
        chk("t1_rx_pulses", rxc0 - base_rx, 1);
        chk("t1_ready", tx_ready0, 1);

        // Mode 3: back-to-back 0x12, 0x34 under one CS; 0xFF pushed once 0x81 has been loaded.
        push_tx(1, 8'h81);
        tx_q3.push_back(8'h81);
        tx_q3.push_back(8'hFF);
        base_und = und3; base_rx = rxc3;
        begin_frame(1);
        rx_q3.push_back(8'h12);
        rx_q3.push_back(8'h34);
        fork
            begin
                xfer_word(1, 8'h12, 8, 1'b1);
                xfer_word(1, 8'h34, 8, 1'b1);
            end
            push_tx(1, 8'hFF);
        join
        end_frame(1);
        chk("t2_rx_pulses", rxc3 - base_rx, 2);
        chk("t2_und", und3 - base_und, 0);
        chk("t2_ready", tx_ready3, 1);

        // Mode 3, empty buffer: the single load sends TX_FILL and flags one underrun.
        tx_q3.push_back(8'hFF);
        base_und = und3; base_rx = rxc3;
        frame(1, 8'h69);
        chk("t3_und", und3 - base_und, 1);
        chk("t3_rx_pulses", rxc3 - base_rx, 1);

        // Mode 0: CS rises after 5 bits, no word is delivered; then a full 0x5A frame.
        base_rx = rxc0;
        begin_frame(0);
        xfer_word(0, 8'hF0, 5, 1'b0);
        end_frame(0);
        chk("t4_no_rx", rxc0 - base_rx, 0);
        tx_q0.push_back(8'hFF);
        frame(0, 8'h5A);
        chk("t4_rx_pulses", rxc0 - base_rx, 1);

        // Mode 0: reset mid-frame with CS held low; SCLK is then ignored until CS re-falls.
        base_rx = rxc0;
        set_cs(0, 1'b0);
        wait_clks(HALF);
        xfer_word(0, 8'hAA, 3, 1'b0);
        rst = 1'b1;
        wait_clks(3);
        chk_reset(0);
        rst = 1'b0;
        wait_clks(4);
        xfer_word(0, 8'h0F, 8, 1'b0);
        wait_clks(HALF);
        chk("t5_busy", busy0, 0);
        chk("t5_oe", miso_oe0, 0);
        chk("t5_no_rx", rxc0 - base_rx, 0);
        set_cs(0, 1'b1);
        wait_clks(2 * HALF);
        tx_q0.push_back(8'hFF);
        frame(0, 8'hC3);
        chk("t5_rx_pulses", rxc0 - base_rx, 1);

        // Mode 0: tx_valid lands on the CS-fall load cycle with an empty buffer. The load sends
        // TX_FILL; the captured 0xE7 is held and goes out at the next load (the second word).
        base_und = und0; base_rx = rxc0;
        set_cs(0, 1'b0);
        wait_clks(2);
        tx_data0 = 8'hE7; tx_valid0 = 1'b1;
        wait_clks(1);
        tx_valid0 = 1'b0;
        chk("t6_ready_held", tx_ready0, 0);
        wait_clks(1);
        chk("t6_und_at_start", und0 - base_und, 1);
        wait_clks(HALF - 3);
        tx_q0.push_back(8'hFF);
        tx_q0.push_back(8'hE7);
        rx_q0.push_back(8'h11);
        rx_q0.push_back(8'h22);
        xfer_word(0, 8'h11, 8, 1'b1);
        xfer_word(0, 8'h22, 8, 1'b1);
        chk("t6_und_mid", und_mid - base_und, 1);
        end_frame(0);
        chk("t6_und_total", und0 - base_und, 2);
        chk("t6_rx_pulses", rxc0 - base_rx, 2);
        chk("t6_ready", tx_ready0, 1);

        wait_clks(8);
        chk("rx0_left", rx_q0.size(), 0);
        chk("rx3_left", rx_q3.size(), 0);
        chk("tx0_left", tx_q0.size(), 0);
        chk("tx3_left", tx_q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
